// File: rtl/mux16_arbiter.sv
// Two-requester arbiter sharing one registered 16-bit path, with burst-limited round-robin ownership.
// Latency: a word accepted at a clock edge appears on out_data/out_valid right after that edge.
// Backpressure: the owner's ready drops when out_valid is held and out_ready is low; IDLE and reset assert no ready.
module mux16_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        sel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter value at which the current transfer closes the burst.
    localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        w_prio_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_out_valid;
    logic        w_out_valid_nxt;
    logic [15:0] r_out_data;
    logic [15:0] w_out_data_nxt;
    logic        r_sel;

    logic        w_owned;
    logic        w_own_is1;
    logic        w_path_free;
    logic        w_own_valid;
    logic        w_oth_valid;
    logic [15:0] w_own_data;
    logic        w_xfer;
    logic        w_release;

    // Handshake decode: who owns the path, whether the output register can take a word, and release conditions.
    always_comb begin
        w_owned     = (r_state != IDLE);
        w_own_is1   = (r_state == OWN1);
        w_path_free = !r_out_valid || out_ready;
        // Ready is gated by rst so no word is accepted on a reset edge.
        req0_ready  = !rst && (r_state == OWN0) && w_path_free;
        req1_ready  = !rst && (r_state == OWN1) && w_path_free;
        w_own_valid = w_own_is1 ? req1_valid : req0_valid;
        w_oth_valid = w_own_is1 ? req0_valid : req1_valid;
        // The shared 2:1 data mux is steered by the registered owner select.
        w_own_data  = r_sel ? req1_data : req0_data;
        w_xfer      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        // Burst end or owner going quiet hands the path to the other side.
        w_release   = w_owned && ((w_xfer && (r_cnt == LAST_CNT)) || !w_own_valid);
    end

    // Next-state logic for ownership, priority pointer and burst counter.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_state_nxt = r_prio ? OWN1 : OWN0;
                end else if (req0_valid) begin
                    w_state_nxt = OWN0;
                end else if (req1_valid) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (w_release) begin
                    // Priority always moves to the side that did not just own the path.
                    w_prio_nxt = !w_own_is1;
                    w_cnt_nxt  = 4'd0;
                    if (w_oth_valid) begin
                        w_state_nxt = w_own_is1 ? OWN0 : OWN1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_prio_nxt  = 1'b0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output register update: load on transfer, clear valid on drain, otherwise hold (ownership changes do not touch it).
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        if (w_xfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_own_data;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // State and datapath registers; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_prio      <= w_prio_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= (w_state_nxt == OWN1);
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel       = r_sel;

endmodule

// File: tb/tb_mux16_arbiter.sv
module tb_mux16_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0;
    logic        v1;
    logic        ordy;
    logic [15:0] d0 [2];
    logic [15:0] d1 [2];
    logic        r0 [2];
    logic        r1 [2];
    logic        ov [2];
    logic        sl [2];
    logic [15:0] od [2];

    // Instance 0 uses BURST=4, instance 1 uses BURST=1; both see the same control stimulus.
    mux16_arbiter #(.BURST(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0[0]), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_data(d1[0]), .req1_ready(r1[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy), .sel(sl[0])
    );

    mux16_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0[1]), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_data(d1[1]), .req1_ready(r1[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy), .sel(sl[1])
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: owner is -1 (nobody), 0 or 1; grants counts words in the current ownership.
    int          m_own    [2];
    int          m_prio   [2];
    int          m_grants [2];
    bit          m_ov     [2];
    logic [15:0] m_od     [2];
    int          burst_len [2] = '{4, 1};
    int          seq0 [2];
    int          seq1 [2];
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];
    logic [15:0] log0 [$];
    logic [15:0] log1 [$];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s dut%0d got %h expected %h at %0t", tag, k, obs, exp, $time);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]    = -1;
            m_prio[k]   = 0;
            m_grants[k] = 0;
            m_ov[k]     = 1'b0;
            m_od[k]     = 16'h0000;
        end
        sb0.delete();
        sb1.delete();
    endfunction

    // One clock cycle: drive at the falling edge, check settled outputs, then advance the model for the next rising edge.
    task automatic step(input bit irst, input bit i0, input bit i1, input bit iord);
        @(negedge clk);
        rst  = irst;
        v0   = i0;
        v1   = i1;
        ordy = iord;
        for (int k = 0; k < 2; k++) begin
            d0[k] = 16'(seq0[k]) & 16'h7fff;
            d1[k] = 16'h8000 | (16'(seq1[k]) & 16'h7fff);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            bit          pf;
            bit          acc;
            bit          vv [2];
            int          o;
            logic [15:0] dat;
            logic [15:0] w;
            pf    = !m_ov[k] || iord;
            vv[0] = i0;
            vv[1] = i1;
            chk("req0_ready", k, 32'(r0[k]), 32'(!irst && m_own[k] == 0 && pf));
            chk("req1_ready", k, 32'(r1[k]), 32'(!irst && m_own[k] == 1 && pf));
            chk("sel", k, 32'(sl[k]), 32'(m_own[k] == 1));
            chk("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
            chk("out_data", k, 32'(od[k]), 32'(m_od[k]));
            // Scoreboard on the observed downstream handshake: order, no loss, no duplicate.
            if (!irst && ov[k] === 1'b1 && iord) begin
                if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                    chk("sb_extra_word", k, 32'(od[k]), 32'hdead_beef);
                end else begin
                    w = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk("sb_order", k, 32'(od[k]), 32'(w));
                    if (k == 0) log0.push_back(od[k]);
                    else        log1.push_back(od[k]);
                end
            end
            if (irst) begin
                if (k == 0) sb0.delete();
                else        sb1.delete();
                m_own[k]    = -1;
                m_prio[k]   = 0;
                m_grants[k] = 0;
                m_ov[k]     = 1'b0;
                m_od[k]     = 16'h0000;
            end else begin
                o   = m_own[k];
                acc = 1'b0;
                dat = 16'h0000;
                if (o < 0) begin
                    if (i0 && i1)  m_own[k] = m_prio[k];
                    else if (i0)   m_own[k] = 0;
                    else if (i1)   m_own[k] = 1;
                end else begin
                    acc = vv[o] && pf;
                    dat = (o == 0) ? d0[k] : d1[k];
                    if ((acc && m_grants[k] + 1 == burst_len[k]) || !vv[o]) begin
                        m_prio[k]   = 1 - o;
                        m_grants[k] = 0;
                        m_own[k]    = vv[1 - o] ? 1 - o : -1;
                    end else if (acc) begin
                        m_grants[k]++;
                    end
                end
                if (acc) begin
                    m_ov[k] = 1'b1;
                    m_od[k] = dat;
                    if (k == 0) sb0.push_back(dat);
                    else        sb1.push_back(dat);
                    if (o == 0) seq0[k]++;
                    else        seq1[k]++;
                end else if (m_ov[k] && iord) begin
                    m_ov[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] e;
        rst  = 1'b1;
        v0   = 1'b0;
        v1   = 1'b0;
        ordy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d0[k] = 16'h0; d1[k] = 16'h0; seq0[k] = 0; seq1[k] = 0;
        end
        repeat (2) @(posedge clk);
        model_reset();

        // First word after reset: granted on cycle 1, visible after edge 2.
        step(1, 0, 0, 1);
        seq0 = '{32'h1234, 32'h1234};
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("first_ready", 0, 32'(r0[0]), 32'd1);
        chk("first_sel", 0, 32'(sl[0]), 32'd0);
        step(0, 1, 0, 1);
        chk("first_data", 0, 32'(od[0]), 32'h1234);
        chk("first_valid", 0, 32'(ov[0]), 32'd1);

        // Both valid, full throughput: burst interleave for BURST=4 and strict alternation for BURST=1.
        step(1, 0, 0, 1);
        seq0 = '{0, 0};
        seq1 = '{0, 0};
        log0.delete();
        log1.delete();
        repeat (12) step(0, 1, 1, 1);
        for (int i = 0; i < 9; i++) begin
            e = (i < 4) ? 16'(i) : (i < 8) ? (16'h8000 | 16'(i - 4)) : 16'h0004;
            chk("burst4_seq", 0, (log0.size() > i) ? 32'(log0[i]) : 32'hffff_ffff, 32'(e));
        end
        for (int i = 0; i < 6; i++) begin
            e = (i % 2 == 0) ? 16'(i / 2) : (16'h8000 | 16'(i / 2));
            chk("burst1_seq", 1, (log1.size() > i) ? 32'(log1[i]) : 32'hffff_ffff, 32'(e));
        end

        // Early release: owner 0 drops valid after two words while requester 1 waits.
        step(1, 0, 0, 1);
        repeat (3) step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("early_release_sel", 0, 32'(sl[0]), 32'd1);

        // Reset in the middle of an OWN1 burst with a word pending.
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("midreset_sel", 0, 32'(sl[0]), 32'd0);
        chk("midreset_valid", 0, 32'(ov[0]), 32'd0);
        chk("midreset_rdy0", 0, 32'(r0[0]), 32'd0);
        chk("midreset_rdy1", 0, 32'(r1[0]), 32'd0);

        // Backpressure hold then resume.
        repeat (5) step(0, 1, 0, 0);
        repeat (4) step(0, 1, 0, 1);
        repeat (3) step(0, 1, 1, 0);
        repeat (4) step(0, 1, 1, 1);

        // Randomized traffic, occasional resets.
        repeat (4000) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
